// File: rtl/ajustare_exponent_if.sv
// Operand/result bundle for the exponent-adjust stage.
// The master drives the operands and sees the result; the slave is the stage itself.
interface ajustare_exponent_if;
  logic       in_valid;
  logic [7:0] exponent;
  logic [8:0] valoare2;
  logic       out_valid;
  logic [7:0] exponentAjustat;
  logic       overflow;
  logic       underflow;

  modport master (
    output in_valid, exponent, valoare2,
    input  out_valid, exponentAjustat, overflow, underflow
  );

  modport slave (
    input  in_valid, exponent, valoare2,
    output out_valid, exponentAjustat, overflow, underflow
  );
endinterface

// File: rtl/ajustare_exponent.sv
// Registered exponent-adjust stage of the single-precision add/subtract datapath (1-cycle latency).
// Build option AJUSTARE_EXP_SAT_EN: saturate out-of-range results (0xFF / 0x00) instead of wrapping.
module ajustare_exponent (
  input logic                 clk,
  input logic                 rst_n,
  ajustare_exponent_if.slave  bus
);

  logic signed [9:0] w_e;
  logic signed [9:0] w_s;
  logic signed [9:0] w_raw;
  logic              w_special;
  logic [7:0]        w_exp_next;
  logic              w_ovf_next;
  logic              w_udf_next;

  logic       r_out_valid;
  logic [7:0] r_exp;
  logic       r_ovf;
  logic       r_udf;

  // Bit 8 set means the mantissa moved right, so the exponent grows.
  assign w_e       = {2'b00, bus.exponent};
  assign w_s       = {2'b00, bus.valoare2[7:0]};
  assign w_raw     = bus.valoare2[8] ? (w_e + w_s) : (w_e - w_s);
  assign w_special = (bus.exponent == 8'hFF);

  // Next exponent and range flags; Inf/NaN exponents pass straight through.
  always_comb begin
    w_exp_next = w_raw[7:0];
    w_ovf_next = 1'b0;
    w_udf_next = 1'b0;
    if (w_special) begin
      w_exp_next = 8'hFF;
      w_ovf_next = 1'b0;
      w_udf_next = 1'b0;
    end else begin
      w_ovf_next = (w_raw >= 10'sd255);
      w_udf_next = (w_raw <= 10'sd0);
`ifdef AJUSTARE_EXP_SAT_EN
      if (w_ovf_next) begin
        w_exp_next = 8'hFF;
      end else if (w_udf_next) begin
        w_exp_next = 8'h00;
      end else begin
        w_exp_next = w_raw[7:0];
      end
`else
      w_exp_next = w_raw[7:0];
`endif
    end
  end

  // Output register: result captured only for valid operands, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_exp       <= 8'h00;
      r_ovf       <= 1'b0;
      r_udf       <= 1'b0;
    end else begin
      r_out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_exp <= w_exp_next;
        r_ovf <= w_ovf_next;
        r_udf <= w_udf_next;
      end else begin
        r_exp <= r_exp;
        r_ovf <= r_ovf;
        r_udf <= r_udf;
      end
    end
  end

  assign bus.out_valid       = r_out_valid;
  assign bus.exponentAjustat = r_exp;
  assign bus.overflow        = r_ovf;
  assign bus.underflow       = r_udf;

endmodule

// File: tb/tb_ajustare_exponent.sv
// Bench for ajustare_exponent: directed vectors with literal expectations, plus a
// per-cycle comparison against an integer-arithmetic model of the stage.
module tb_ajustare_exponent;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  ajustare_exponent_if bus ();

  ajustare_exponent dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef AJUSTARE_EXP_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  // Model state: what the outputs must show after the latest edge.
  logic       m_valid;
  logic [7:0] m_exp;
  logic       m_ovf;
  logic       m_udf;

  function automatic logic [9:0] model(input logic [7:0] e, input logic [8:0] v);
    int r;
    logic [7:0] x;
    logic o, u;
    if (v[8]) r = int'(e) + int'(v[7:0]);
    else      r = int'(e) - int'(v[7:0]);
    o = 1'b0;
    u = 1'b0;
    if (e == 8'd255) begin
      x = 8'd255;
    end else begin
      o = (r >= 255);
      u = (r <= 0);
      x = 8'((r + 512) % 256);
      if (SAT && o) x = 8'd255;
      if (SAT && u) x = 8'd0;
    end
    return {x, o, u};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_exp   <= 8'h00;
      m_ovf   <= 1'b0;
      m_udf   <= 1'b0;
    end else begin
      m_valid <= bus.in_valid;
      if (bus.in_valid) begin
        {m_exp, m_ovf, m_udf} <= model(bus.exponent, bus.valoare2);
      end
    end
  end

  // Per-cycle compare against the model, on the inactive edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("model", {21'd0, bus.out_valid, bus.exponentAjustat, bus.overflow, bus.underflow},
                   {21'd0, m_valid, m_exp, m_ovf, m_udf});
    end
  end

  // Drive one operand now (caller sits on a negedge) and check the result one cycle later.
  task automatic vec(input string name, input logic [7:0] e, input logic [8:0] v,
                     input logic [7:0] x_exp, input logic x_ovf, input logic x_udf);
    bus.in_valid = 1'b1;
    bus.exponent = e;
    bus.valoare2 = v;
    @(negedge clk);
    chk(name, {21'd0, bus.out_valid, bus.exponentAjustat, bus.overflow, bus.underflow},
              {21'd0, 1'b1, x_exp, x_ovf, x_udf});
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.exponent = 8'h00;
    bus.valoare2 = 9'h000;
    repeat (3) @(negedge clk);
    chk("reset", {21'd0, bus.out_valid, bus.exponentAjustat, bus.overflow, bus.underflow}, 32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);

    vec("sub",        8'h80, 9'h005, 8'h7B, 1'b0, 1'b0);
    vec("add",        8'h7F, 9'h101, 8'h80, 1'b0, 1'b0);
    vec("ovf",        8'hFE, 9'h102, SAT ? 8'hFF : 8'h00, 1'b1, 1'b0);
    vec("udf",        8'h03, 9'h005, SAT ? 8'h00 : 8'hFE, 1'b0, 1'b1);
    vec("udf_zero",   8'h05, 9'h005, 8'h00, 1'b0, 1'b1);
    vec("special",    8'hFF, 9'h003, 8'hFF, 1'b0, 1'b0);
    vec("special_up", 8'hFF, 9'h1FF, 8'hFF, 1'b0, 1'b0);
    vec("zero_sub",   8'h42, 9'h000, 8'h42, 1'b0, 1'b0);
    vec("zero_add",   8'h42, 9'h100, 8'h42, 1'b0, 1'b0);
    vec("top_in",     8'hFD, 9'h101, 8'hFE, 1'b0, 1'b0);
    vec("ovf_255",    8'hFE, 9'h101, 8'hFF, 1'b1, 1'b0);
    vec("bot_in",     8'h02, 9'h001, 8'h01, 1'b0, 1'b0);
    vec("ovf_max",    8'hFE, 9'h1FF, SAT ? 8'hFF : 8'hFD, 1'b1, 1'b0);
    vec("udf_min",    8'h00, 9'h0FF, SAT ? 8'h00 : 8'h01, 1'b0, 1'b1);
    vec("zero_exp",   8'h00, 9'h101, 8'h01, 1'b0, 1'b0);

    // Idle cycle: valid drops, data and flags hold.
    bus.in_valid = 1'b0;
    bus.exponent = 8'h10;
    bus.valoare2 = 9'h003;
    @(negedge clk);
    chk("idle_hold", {21'd0, bus.out_valid, bus.exponentAjustat, bus.overflow, bus.underflow},
                     {21'd0, 1'b0, 8'h01, 1'b0, 1'b0});

    // Reset mid-stream: three back-to-back operands, reset between edges.
    bus.in_valid = 1'b1;
    bus.exponent = 8'h20;
    bus.valoare2 = 9'h101;
    @(negedge clk);
    bus.exponent = 8'h30;
    @(negedge clk);
    bus.exponent = 8'h40;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", {21'd0, bus.out_valid, bus.exponentAjustat, bus.overflow, bus.underflow}, 32'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("no_stale", {21'd0, bus.out_valid, bus.exponentAjustat, bus.overflow, bus.underflow}, 32'd0);

    vec("post_rst", 8'h10, 9'h002, 8'h0E, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
